fifo_read_controller: RTL and testbench
=======================================

// Module: fifo_read_controller
// PURPOSE
//  Synthesizable consumer for the Fifo block: generates the active-low read strobe (Fifo iRDCLKN)
//  and captures the popped word. Presents each word downstream on a single-entry valid/ready port.
//  Optionally checks an incrementing-by-one data sequence. Sits between the Fifo and on-chip sinks.
//  All logic runs on one clock; the strobe is a registered output, never a gated clock.
// PARAMETERS
//  WIDTH        8  data width; must match Fifo WIDTH
//  LOW_CYCLES   3  cycles oRDCLKN is held low per pop (>=2); data sampled on the last low cycle
//  HIGH_CYCLES  2  minimum cycles oRDCLKN is held high after each pop (>=1)
//  SYNC_STAGES  2  flops on iFifoEmpty before use (>=1)
//  CHECK_SEQ    1  1 = enable sequence checker driving oSeqError; 0 = oSeqError tied 0
// PORTS
//  iCLK        in   1      single clock, rising-edge
//  iRSTN       in   1      reset, synchronous, active-low
//  iEnable     in   1      1 = allowed to start new pops
//  iFifoEmpty  in   1      Fifo oEmpty (asynchronous to logic, synchronized internally)
//  iFifoData   in   WIDTH  Fifo oData
//  oRDCLKN     out  1      read strobe to Fifo iRDCLKN; Fifo pops on its falling edge
//  oData       out  WIDTH  captured word
//  oValid      out  1      oData holds an unconsumed word
//  iReady      in   1      downstream accepts; transfer = oValid & iReady at rising iCLK
//  oWordCount  out  16     words captured since reset, wraps 65535->0
//  oSeqError   out  1      sticky: captured word != expected
//  oBusy       out  1      1 when FSM not in IDLE
// BEHAVIOUR
//  Reset (iRSTN=0 at rising iCLK): oRDCLKN=1, oData=0, oValid=0, oWordCount=0, oSeqError=0, oBusy=0.
//   Reset also sets FSM=IDLE, expected=0, and empty sync chain preset to 1.
//  FSM states:
//   IDLE: oRDCLKN=1. Go to LOW when iEnable=1 & empty_s=0 & (oValid=0 | iReady=1).
//         oRDCLKN falls on that same edge.
//   LOW: oRDCLKN=0 for exactly LOW_CYCLES cycles. On the final LOW edge:
//         oData<=iFifoData, oValid<=1, oWordCount+=1, oRDCLKN<=1; go to HIGH.
//   HIGH: oRDCLKN=1 for HIGH_CYCLES+SYNC_STAGES cycles so the updated Fifo oEmpty reaches empty_s;
//         then go to IDLE.
//  Pop period with no stall: 1+LOW_CYCLES+HIGH_CYCLES+SYNC_STAGES = 8 cycles at defaults.
//  oValid handshake:
//   Clears on the transfer edge unless a capture occurs on the same edge.
//   oData is stable while oValid=1 & iReady=0.
//   The start rule guarantees the buffer is free at capture; no data is ever overwritten.
//  Sequence check (CHECK_SEQ=1): at capture, compare iFifoData with expected.
//   On mismatch, oSeqError<=1 (sticky until reset).
//   expected increments by 1 mod 2^WIDTH every capture, match or not; 0xFF->0x00 is not an error.
//  Boundary rules:
//   iFifoEmpty rising during LOW/HIGH is ignored; the current pop completes.
//   It is only sampled in IDLE.
//   iEnable dropping mid-pop: the pop completes, then no new pop starts.
//   Reset mid-LOW: oRDCLKN returns high on the reset edge (Fifo sees only a rising edge);
//    the in-flight word is discarded and all outputs take reset values.
//   oWordCount and expected wrap silently.
// TESTING
//  T1 reset, iEnable=1, iFifoEmpty=1 for 50 cycles -> oRDCLKN stays 1, oValid=0, oBusy=0
//  T2 Fifo model holds 0x00..0x0E, iReady=1 -> 15 falls of oRDCLKN, each low 3 cycles, 8 cycles apart;
//     oData 0x00..0x0E in order; oWordCount=15, oSeqError=0; idle once empty
//  T3 as T2 but iReady=0 after the first word -> oData=0x00 held, no further strobe fall;
//     a one-cycle iReady pulse yields exactly one more pop
//  T4 Fifo holds 0x00,0x01,0x05 -> oSeqError rises on the 3rd capture edge and stays 1
//  T5 258 words 0x00..0xFF,0x00,0x01 -> oSeqError=0, oWordCount=258
//  T6 iRSTN=0 on the 2nd LOW cycle -> next edge oRDCLKN=1, oValid=0, oWordCount=0;
//     after release, the next pop expects 0x00

Source files
------------

// File: rtl/fifo_read_controller_if.sv
// Fifo-side and downstream-side signals of the Fifo read controller.
// The controller uses the master modport. A Fifo model or a sink uses the slave modport.
interface fifo_read_controller_if #(
    parameter int WIDTH = 8
);
    logic             iFifoEmpty;
    logic [WIDTH-1:0] iFifoData;
    logic             oRDCLKN;
    logic [WIDTH-1:0] oData;
    logic             oValid;
    logic             iReady;

    modport master (
        input  iFifoEmpty,
        input  iFifoData,
        input  iReady,
        output oRDCLKN,
        output oData,
        output oValid
    );

    modport slave (
        output iFifoEmpty,
        output iFifoData,
        output iReady,
        input  oRDCLKN,
        input  oData,
        input  oValid
    );
endinterface

// File: rtl/fifo_read_controller.sv
// Pops the Fifo with a registered active-low read strobe and captures each popped word.
// It presents each word on a single-entry valid/ready port and can check for an incrementing data sequence.
module fifo_read_controller #(
    parameter int WIDTH       = 8,
    parameter int LOW_CYCLES  = 3,
    parameter int HIGH_CYCLES = 2,
    parameter int SYNC_STAGES = 2,
    parameter int CHECK_SEQ   = 1
) (
    input  logic                        iCLK,
    input  logic                        iRSTN,
    input  logic                        iEnable,
    fifo_read_controller_if.master      bus,
    output logic [15:0]                 oWordCount,
    output logic                        oSeqError,
    output logic                        oBusy
);
    localparam int HOLD_HIGH = HIGH_CYCLES + SYNC_STAGES;
    localparam int CNT_MAX   = (LOW_CYCLES > HOLD_HIGH) ? LOW_CYCLES : HOLD_HIGH;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HOLD_HIGH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   r_rdclkn;
    logic                   w_rdclkn_next;
    logic                   w_capture;
    logic                   w_transfer;
    logic                   w_empty_s;
    logic [SYNC_STAGES-1:0] r_empty_sync;
    logic [WIDTH-1:0]       r_data;
    logic                   r_valid;
    logic [15:0]            r_word_count;
    logic [WIDTH-1:0]       r_expected;
    logic                   r_seq_error;

    // The empty flag comes from the Fifo domain. It is synchronized here, and reset presets it to "empty".
    always_ff @(posedge iCLK) begin
        if (!iRSTN) begin
            r_empty_sync <= '1;
        end else begin
            r_empty_sync[0] <= bus.iFifoEmpty;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_empty_sync[i] <= r_empty_sync[i-1];
            end
        end
    end

    assign w_empty_s  = r_empty_sync[SYNC_STAGES-1];
    assign w_transfer = r_valid & bus.iReady;

    always_comb begin
        // NOTE: every signal gets a default first. This keeps paths that skip a branch from inferring a latch.
        w_state_next  = r_state;
        w_cnt_next    = r_cnt;
        w_rdclkn_next = 1'b1;
        w_capture     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (iEnable && !w_empty_s && (!r_valid || bus.iReady)) begin
                    w_state_next  = S_LOW;
                    w_cnt_next    = '0;
                    w_rdclkn_next = 1'b0;
                end
            end
            S_LOW: begin
                w_rdclkn_next = 1'b0;
                if (r_cnt == LOW_LAST) begin
                    w_capture     = 1'b1;
                    w_state_next  = S_HIGH;
                    w_cnt_next    = '0;
                    w_rdclkn_next = 1'b1;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_HIGH: begin
                // Stay high long enough for the post-pop empty flag to pass through the synchronizer.
                if (r_cnt == HIGH_LAST) begin
                    w_state_next = S_IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments. Every flop then samples pre-edge values, so there is no ordering race.
    always_ff @(posedge iCLK) begin
        if (!iRSTN) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_rdclkn <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            r_cnt    <= w_cnt_next;
            r_rdclkn <= w_rdclkn_next;
        end
    end

    // The start rule guarantees the buffer is empty at capture. Capture therefore never coincides with a pending transfer.
    always_ff @(posedge iCLK) begin
        if (!iRSTN) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_word_count <= '0;
            r_expected   <= '0;
            r_seq_error  <= 1'b0;
        end else begin
            if (w_capture) begin
                r_data       <= bus.iFifoData;
                r_valid      <= 1'b1;
                r_word_count <= r_word_count + 16'd1;
                r_expected   <= r_expected + WIDTH'(1);
                if ((CHECK_SEQ != 0) && (bus.iFifoData != r_expected)) begin
                    r_seq_error <= 1'b1;
                end
            end else if (w_transfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.oRDCLKN = r_rdclkn;
    assign bus.oData   = r_data;
    assign bus.oValid  = r_valid;
    assign oWordCount  = r_word_count;
    assign oSeqError   = r_seq_error;
    assign oBusy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_fifo_read_controller.sv
// Directed bench for fifo_read_controller. A Fifo model pops on the falling edge of the strobe.
// A scoreboard checks every transferred word, and a strobe monitor checks pulse width and pop spacing.
module tb_fifo_read_controller;
    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic [15:0] word_count;
    logic        seq_error;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    fifo_read_controller_if #(.WIDTH(8)) bus ();

    fifo_read_controller #(
        .WIDTH(8), .LOW_CYCLES(3), .HIGH_CYCLES(2), .SYNC_STAGES(2), .CHECK_SEQ(1)
    ) dut (
        .iCLK       (clk),
        .iRSTN      (rstn),
        .iEnable    (enable),
        .bus        (bus.master),
        .oWordCount (word_count),
        .oSeqError  (seq_error),
        .oBusy      (busy)
    );

    always #5 clk = ~clk;

    // Fifo model: the falling strobe edge moves the head word onto the data output.
    logic [7:0] fifo_mem[$];
    logic [7:0] sb[$];
    assign bus.iFifoEmpty = (fifo_mem.size() == 0);
    always @(negedge bus.oRDCLKN) begin
        if (fifo_mem.size() != 0) bus.iFifoData = fifo_mem.pop_front();
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor and scoreboard. They sample on the falling clock edge, away from the DUT's active edge.
    int cyc = 0;
    int falls[$];
    int lows[$];
    int low_run = 0;
    logic prev_rd = 1'b1;
    always @(posedge clk) cyc++;
    always @(negedge clk) begin
        if (bus.oRDCLKN === 1'b0) begin
            if (prev_rd === 1'b1) falls.push_back(cyc);
            low_run++;
        end else if (low_run != 0) begin
            lows.push_back(low_run);
            low_run = 0;
        end
        prev_rd = bus.oRDCLKN;
        if (rstn && bus.oValid && bus.iReady) begin
            if (sb.size() == 0) check("sb_unexpected_word", {24'd0, bus.oData}, 32'hFFFF_FFFF);
            else check("sb_data", {24'd0, bus.oData}, {24'd0, sb.pop_front()});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rstn   = 1'b0;
        enable = 1'b0;
        bus.iReady = 1'b0;
        fifo_mem.delete();
        sb.delete();
        step(2);
        rstn = 1'b1;
    endtask

    task automatic push_word(input logic [7:0] w);
        fifo_mem.push_back(w);
        sb.push_back(w);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (!(fifo_mem.size() == 0 && !busy) && n < budget) begin
            step(1);
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    task automatic wait_count(input string tag, input logic [15:0] target, input int budget);
        int n = 0;
        while (word_count !== target && n < budget) begin
            step(1);
            n++;
        end
        check(tag, n < budget, 1);
    endtask

    int base_f;
    int base_l;

    initial begin
        bus.iReady = 1'b0;
        enable     = 1'b0;
        rstn       = 1'b0;
        step(1);

        // T1: reset state, then enabled with an empty Fifo.
        do_reset();
        check("rst_rdclkn", bus.oRDCLKN, 1);
        check("rst_data", bus.oData, 0);
        check("rst_valid", bus.oValid, 0);
        check("rst_count", word_count, 0);
        check("rst_seqerr", seq_error, 0);
        check("rst_busy", busy, 0);
        base_f = falls.size();
        enable = 1'b1;
        step(50);
        check("t1_no_falls", falls.size() - base_f, 0);
        check("t1_valid", bus.oValid, 0);
        check("t1_busy", busy, 0);

        // T2: 15 words with the sink always ready.
        do_reset();
        base_f = falls.size();
        base_l = lows.size();
        for (int i = 0; i < 15; i++) push_word(8'(i));
        bus.iReady = 1'b1;
        enable = 1'b1;
        wait_idle("t2_drain_timeout", 300);
        step(4);
        check("t2_falls", falls.size() - base_f, 15);
        for (int i = 0; i < 15 && base_l + i < lows.size(); i++)
            check("t2_low_width", lows[base_l + i], 3);
        for (int i = 1; i < 15 && base_f + i < falls.size(); i++)
            check("t2_pop_period", falls[base_f + i] - falls[base_f + i - 1], 8);
        check("t2_count", word_count, 15);
        check("t2_seqerr", seq_error, 0);
        check("t2_busy", busy, 0);
        check("t2_sb_empty", sb.size(), 0);

        // T3: backpressure holds the first word. A one-cycle ready pulse allows exactly one more pop.
        do_reset();
        base_f = falls.size();
        for (int i = 0; i < 5; i++) push_word(8'(i));
        enable = 1'b1;
        step(40);
        check("t3_falls_held", falls.size() - base_f, 1);
        check("t3_valid_held", bus.oValid, 1);
        check("t3_data_held", bus.oData, 8'h00);
        bus.iReady = 1'b1;
        step(1);
        bus.iReady = 1'b0;
        step(40);
        check("t3_falls_pulse", falls.size() - base_f, 2);
        check("t3_data_next", bus.oData, 8'h01);
        check("t3_count", word_count, 2);

        // T4: 0x00, 0x01, 0x05. The error rises on the third capture edge and stays set.
        do_reset();
        push_word(8'h00);
        push_word(8'h01);
        push_word(8'h05);
        bus.iReady = 1'b1;
        enable = 1'b1;
        wait_count("t4_wait2", 16'd2, 100);
        check("t4_seqerr_before", seq_error, 0);
        wait_count("t4_wait3", 16'd3, 100);
        check("t4_seqerr_at", seq_error, 1);
        step(20);
        check("t4_seqerr_sticky", seq_error, 1);

        // T5: 258 words across the 0xFF->0x00 wrap.
        do_reset();
        for (int i = 0; i < 258; i++) push_word(8'(i));
        bus.iReady = 1'b1;
        enable = 1'b1;
        wait_idle("t5_drain_timeout", 258 * 8 + 100);
        step(4);
        check("t5_count", word_count, 258);
        check("t5_seqerr", seq_error, 0);
        check("t5_sb_empty", sb.size(), 0);

        // T6: reset on the second LOW cycle, then restart the sequence from 0x00.
        do_reset();
        for (int i = 0; i < 10; i++) push_word(8'(i));
        bus.iReady = 1'b1;
        enable = 1'b1;
        wait_count("t6_wait2", 16'd2, 100);
        begin
            int n = 0;
            while (bus.oRDCLKN !== 1'b0 && n < 50) begin
                step(1);
                n++;
            end
            check("t6_fall_timeout", n < 50, 1);
        end
        step(1);
        rstn = 1'b0;
        step(1);
        check("t6_rdclkn", bus.oRDCLKN, 1);
        check("t6_valid", bus.oValid, 0);
        check("t6_count", word_count, 0);
        check("t6_busy", busy, 0);
        fifo_mem.delete();
        sb.delete();
        rstn = 1'b1;
        push_word(8'h00);
        push_word(8'h01);
        wait_idle("t6_drain_timeout", 100);
        step(4);
        check("t6_seqerr", seq_error, 0);
        check("t6_count_after", word_count, 2);
        check("t6_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
